// File: rtl/cci_mpf_shim_req_throttle.sv
// cci_mpf_shim_req_throttle
// Request-admission shim between the AFU and the MPF pipeline. Request
// headers pass through a one-cycle register. In-flight lines are counted per
// channel (c0 reads, c1 writes), and a registered almost-full is raised early
// enough that MPF's outstanding-request limit is not exceeded. Protocol
// violations latch sticky error flags that only reset clears.
module cci_mpf_shim_req_throttle #(
  parameter int MAX_ACTIVE_REQS = 128,
  parameter int AF_SLACK        = 8,
  parameter int HDR_WIDTH       = 80,
  localparam int CNT_WIDTH      = $clog2(MAX_ACTIVE_REQS + AF_SLACK + 1)
) (
  input  logic                 clk,
  input  logic                 reset,

  input  logic                 afu_c0_req_valid,
  input  logic [HDR_WIDTH-1:0] afu_c0_req_hdr,
  input  logic [1:0]           afu_c0_req_cl_len,
  output logic                 afu_c0_almost_full,
  output logic                 fiu_c0_req_valid,
  output logic [HDR_WIDTH-1:0] fiu_c0_req_hdr,
  input  logic                 fiu_c0_almost_full,
  input  logic                 fiu_c0_rsp_valid,

  input  logic                 afu_c1_req_valid,
  input  logic [HDR_WIDTH-1:0] afu_c1_req_hdr,
  output logic                 afu_c1_almost_full,
  output logic                 fiu_c1_req_valid,
  output logic [HDR_WIDTH-1:0] fiu_c1_req_hdr,
  input  logic                 fiu_c1_almost_full,
  input  logic                 fiu_c1_rsp_valid,
  input  logic [2:0]           fiu_c1_rsp_lines,

  output logic [CNT_WIDTH-1:0] c0_active,
  output logic [CNT_WIDTH-1:0] c1_active,
  output logic                 err_overflow,
  output logic                 err_underflow,
  output logic                 err_bad_len
);

  localparam int CNT_MAX = (1 << CNT_WIDTH) - 1;

  logic [2:0]           c0_inc, c0_dec, c1_inc, c1_dec;
  logic                 c0_len_bad, c1_len_bad;
  int                   c0_sum, c1_sum;
  logic [CNT_WIDTH-1:0] c0_next, c1_next;
  logic                 c0_af_next, c1_af_next;
  logic                 over_next, under_next, bad_next;

  // A negative net result clamps to zero; anything beyond the counter's
  // range pins at all-ones. Values between MAX and all-ones are kept exact.
  function automatic logic [CNT_WIDTH-1:0] clamp_count(input int sum);
    if (sum < 0)
      clamp_count = '0;
    else if (sum > CNT_MAX)
      clamp_count = CNT_WIDTH'(CNT_MAX);
    else
      clamp_count = CNT_WIDTH'(sum);
  endfunction

  // Net line delta per channel, next counts, thresholds and error conditions.
  always_comb begin
    c0_inc     = 3'd0;
    c0_len_bad = 1'b0;
    if (afu_c0_req_valid) begin
      case (afu_c0_req_cl_len)
        2'd0:    c0_inc = 3'd1;
        2'd1:    c0_inc = 3'd2;
        2'd3:    c0_inc = 3'd4;
        default: begin
          c0_inc     = 3'd1;
          c0_len_bad = 1'b1;
        end
      endcase
    end
    c0_dec = fiu_c0_rsp_valid ? 3'd1 : 3'd0;

    c1_inc     = afu_c1_req_valid ? 3'd1 : 3'd0;
    c1_dec     = 3'd0;
    c1_len_bad = 1'b0;
    if (fiu_c1_rsp_valid) begin
      if ((fiu_c1_rsp_lines >= 3'd1) && (fiu_c1_rsp_lines <= 3'd4))
        c1_dec = fiu_c1_rsp_lines;
      else
        c1_len_bad = 1'b1;
    end

    c0_sum  = int'(c0_active) + int'(c0_inc) - int'(c0_dec);
    c1_sum  = int'(c1_active) + int'(c1_inc) - int'(c1_dec);
    c0_next = clamp_count(c0_sum);
    c1_next = clamp_count(c1_sum);

    c0_af_next = fiu_c0_almost_full |
                 ((int'(c0_next) + AF_SLACK) >= MAX_ACTIVE_REQS);
    c1_af_next = fiu_c1_almost_full |
                 ((int'(c1_next) + AF_SLACK) >= MAX_ACTIVE_REQS);

    over_next  = (c0_sum > MAX_ACTIVE_REQS) || (c1_sum > MAX_ACTIVE_REQS);
    under_next = (c0_sum < 0) || (c1_sum < 0);
    bad_next   = c0_len_bad || c1_len_bad;
  end

  // Request pass-through register; requests held off by reset are dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fiu_c0_req_valid <= 1'b0;
      fiu_c0_req_hdr   <= '0;
      fiu_c1_req_valid <= 1'b0;
      fiu_c1_req_hdr   <= '0;
    end else begin
      fiu_c0_req_valid <= afu_c0_req_valid;
      fiu_c0_req_hdr   <= afu_c0_req_hdr;
      fiu_c1_req_valid <= afu_c1_req_valid;
      fiu_c1_req_hdr   <= afu_c1_req_hdr;
    end
  end

  // Line counters and almost-full update together from the same next value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      c0_active          <= '0;
      c1_active          <= '0;
      afu_c0_almost_full <= 1'b0;
      afu_c1_almost_full <= 1'b0;
    end else begin
      c0_active          <= c0_next;
      c1_active          <= c1_next;
      afu_c0_almost_full <= c0_af_next;
      afu_c1_almost_full <= c1_af_next;
    end
  end

  // Sticky error flags; once set they stay set until reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
      err_bad_len   <= 1'b0;
    end else begin
      err_overflow  <= err_overflow  | over_next;
      err_underflow <= err_underflow | under_next;
      err_bad_len   <= err_bad_len   | bad_next;
    end
  end

endmodule

// File: tb/tb_cci_mpf_shim_req_throttle.sv
// tb_cci_mpf_shim_req_throttle
// Directed bench for the request throttle shim with hand-computed expectations.
module tb_cci_mpf_shim_req_throttle;

  localparam int HDR_WIDTH = 80;
  localparam int CNT_WIDTH = 8;

  logic                 clk;
  logic                 reset;
  logic                 afu_c0_req_valid;
  logic [HDR_WIDTH-1:0] afu_c0_req_hdr;
  logic [1:0]           afu_c0_req_cl_len;
  logic                 afu_c0_almost_full;
  logic                 fiu_c0_req_valid;
  logic [HDR_WIDTH-1:0] fiu_c0_req_hdr;
  logic                 fiu_c0_almost_full;
  logic                 fiu_c0_rsp_valid;
  logic                 afu_c1_req_valid;
  logic [HDR_WIDTH-1:0] afu_c1_req_hdr;
  logic                 afu_c1_almost_full;
  logic                 fiu_c1_req_valid;
  logic [HDR_WIDTH-1:0] fiu_c1_req_hdr;
  logic                 fiu_c1_almost_full;
  logic                 fiu_c1_rsp_valid;
  logic [2:0]           fiu_c1_rsp_lines;
  logic [CNT_WIDTH-1:0] c0_active;
  logic [CNT_WIDTH-1:0] c1_active;
  logic                 err_overflow;
  logic                 err_underflow;
  logic                 err_bad_len;

  int total;
  int bad;

  cci_mpf_shim_req_throttle #(
    .MAX_ACTIVE_REQS(128),
    .AF_SLACK(8),
    .HDR_WIDTH(HDR_WIDTH)
  ) dut (
    .clk(clk),
    .reset(reset),
    .afu_c0_req_valid(afu_c0_req_valid),
    .afu_c0_req_hdr(afu_c0_req_hdr),
    .afu_c0_req_cl_len(afu_c0_req_cl_len),
    .afu_c0_almost_full(afu_c0_almost_full),
    .fiu_c0_req_valid(fiu_c0_req_valid),
    .fiu_c0_req_hdr(fiu_c0_req_hdr),
    .fiu_c0_almost_full(fiu_c0_almost_full),
    .fiu_c0_rsp_valid(fiu_c0_rsp_valid),
    .afu_c1_req_valid(afu_c1_req_valid),
    .afu_c1_req_hdr(afu_c1_req_hdr),
    .afu_c1_almost_full(afu_c1_almost_full),
    .fiu_c1_req_valid(fiu_c1_req_valid),
    .fiu_c1_req_hdr(fiu_c1_req_hdr),
    .fiu_c1_almost_full(fiu_c1_almost_full),
    .fiu_c1_rsp_valid(fiu_c1_rsp_valid),
    .fiu_c1_rsp_lines(fiu_c1_rsp_lines),
    .c0_active(c0_active),
    .c1_active(c1_active),
    .err_overflow(err_overflow),
    .err_underflow(err_underflow),
    .err_bad_len(err_bad_len)
  );

  // 10 ns free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison: counts it, and reports tag/observed/expected on a miss.
  task automatic checkOutput(input string tag, input logic [HDR_WIDTH-1:0] observed,
                             input logic [HDR_WIDTH-1:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Drives one cycle of inputs, then waits past the next rising edge.
  task automatic applyStimulus(input logic c0v, input logic [1:0] c0len,
                               input logic [HDR_WIDTH-1:0] c0hdr, input logic c0rsp,
                               input logic c1v, input logic [HDR_WIDTH-1:0] c1hdr,
                               input logic c1rsp, input logic [2:0] c1lines);
    afu_c0_req_valid  = c0v;
    afu_c0_req_cl_len = c0len;
    afu_c0_req_hdr    = c0hdr;
    fiu_c0_rsp_valid  = c0rsp;
    afu_c1_req_valid  = c1v;
    afu_c1_req_hdr    = c1hdr;
    fiu_c1_rsp_valid  = c1rsp;
    fiu_c1_rsp_lines  = c1lines;
    @(posedge clk);
    #1;
  endtask

  // Idle inputs, holds reset for two edges, releases it just after an edge.
  task automatic applyReset();
    afu_c0_req_valid   = 1'b0;
    afu_c0_req_cl_len  = 2'd0;
    afu_c0_req_hdr     = '0;
    fiu_c0_rsp_valid   = 1'b0;
    fiu_c0_almost_full = 1'b0;
    afu_c1_req_valid   = 1'b0;
    afu_c1_req_hdr     = '0;
    fiu_c1_rsp_valid   = 1'b0;
    fiu_c1_rsp_lines   = 3'd0;
    fiu_c1_almost_full = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Directed sequence of scenarios.
  initial begin
    logic [HDR_WIDTH-1:0] hdr_a;
    logic [HDR_WIDTH-1:0] hdr_b;
    total = 0;
    bad   = 0;
    hdr_a = 80'hA5A5_1234_5678_9ABC_DEF0;
    hdr_b = 80'h0F0F_CAFE_BEEF_0000_1111;

    // Reset state, with a request held during reset that must not count.
    applyReset();
    afu_c0_req_valid = 1'b1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("rst_c0_during_reset", {72'd0, c0_active}, 80'd0);
    applyReset();
    checkOutput("rst_fiu_c0_valid", {79'd0, fiu_c0_req_valid}, 80'd0);
    checkOutput("rst_fiu_c1_valid", {79'd0, fiu_c1_req_valid}, 80'd0);
    checkOutput("rst_fiu_c0_hdr", fiu_c0_req_hdr, 80'd0);
    checkOutput("rst_fiu_c1_hdr", fiu_c1_req_hdr, 80'd0);
    checkOutput("rst_c0_active", {72'd0, c0_active}, 80'd0);
    checkOutput("rst_c1_active", {72'd0, c1_active}, 80'd0);
    checkOutput("rst_af", {78'd0, afu_c0_almost_full, afu_c1_almost_full}, 80'd0);
    checkOutput("rst_errs", {77'd0, err_overflow, err_underflow, err_bad_len}, 80'd0);

    // Four-line read passes through with its header; c1 header too.
    applyStimulus(1'b1, 2'd3, hdr_a, 1'b0, 1'b1, hdr_b, 1'b0, 3'd0);
    checkOutput("c0_pass_valid", {79'd0, fiu_c0_req_valid}, 80'd1);
    checkOutput("c0_pass_hdr", fiu_c0_req_hdr, hdr_a);
    checkOutput("c1_pass_hdr", fiu_c1_req_hdr, hdr_b);
    checkOutput("c0_len4_count", {72'd0, c0_active}, 80'd4);
    checkOutput("c1_one_count", {72'd0, c1_active}, 80'd1);
    applyStimulus(1'b1, 2'd1, hdr_b, 1'b0, 1'b0, '0, 1'b0, 3'd0);
    checkOutput("c0_len2_count", {72'd0, c0_active}, 80'd6);
    applyStimulus(1'b0, 2'd0, '0, 1'b0, 1'b0, '0, 1'b0, 3'd0);
    checkOutput("c0_idle_valid", {79'd0, fiu_c0_req_valid}, 80'd0);

    // Downstream back-pressure reaches the AFU one cycle later.
    fiu_c1_almost_full = 1'b1;
    #1;
    checkOutput("c1_af_not_yet", {79'd0, afu_c1_almost_full}, 80'd0);
    applyStimulus(1'b0, 2'd0, '0, 1'b0, 1'b0, '0, 1'b0, 3'd0);
    checkOutput("c1_af_downstream", {79'd0, afu_c1_almost_full}, 80'd1);
    checkOutput("c0_af_unaffected", {79'd0, afu_c0_almost_full}, 80'd0);
    fiu_c1_almost_full = 1'b0;
    applyStimulus(1'b0, 2'd0, '0, 1'b0, 1'b0, '0, 1'b0, 3'd0);
    checkOutput("c1_af_release", {79'd0, afu_c1_almost_full}, 80'd0);

    // Almost-full threshold: rises with the 120th line, falls after one return.
    applyReset();
    for (int i = 0; i < 119; i++)
      applyStimulus(1'b1, 2'd0, '0, 1'b0, 1'b0, '0, 1'b0, 3'd0);
    checkOutput("thr_count_119", {72'd0, c0_active}, 80'd119);
    checkOutput("thr_af_below", {79'd0, afu_c0_almost_full}, 80'd0);
    applyStimulus(1'b1, 2'd0, '0, 1'b0, 1'b0, '0, 1'b0, 3'd0);
    checkOutput("thr_count_120", {72'd0, c0_active}, 80'd120);
    checkOutput("thr_af_rise", {79'd0, afu_c0_almost_full}, 80'd1);
    applyStimulus(1'b0, 2'd0, '0, 1'b1, 1'b0, '0, 1'b0, 3'd0);
    checkOutput("thr_count_back", {72'd0, c0_active}, 80'd119);
    checkOutput("thr_af_fall", {79'd0, afu_c0_almost_full}, 80'd0);

    // Simultaneous write request and packed response: 10 + 1 - 4 = 7.
    applyReset();
    for (int i = 0; i < 10; i++)
      applyStimulus(1'b0, 2'd0, '0, 1'b0, 1'b1, '0, 1'b0, 3'd0);
    checkOutput("sim_c1_start", {72'd0, c1_active}, 80'd10);
    applyStimulus(1'b0, 2'd0, '0, 1'b0, 1'b1, hdr_a, 1'b1, 3'd4);
    checkOutput("sim_c1_net", {72'd0, c1_active}, 80'd7);
    checkOutput("sim_no_errs", {77'd0, err_overflow, err_underflow, err_bad_len}, 80'd0);

    // Illegal write response lengths count nothing and flag bad length.
    applyStimulus(1'b0, 2'd0, '0, 1'b0, 1'b0, '0, 1'b1, 3'd5);
    checkOutput("c1_badlen_count", {72'd0, c1_active}, 80'd7);
    checkOutput("c1_badlen_flag", {79'd0, err_bad_len}, 80'd1);

    // Underflow clamps at zero and the flag is sticky.
    applyReset();
    applyStimulus(1'b0, 2'd0, '0, 1'b1, 1'b0, '0, 1'b0, 3'd0);
    checkOutput("under_count", {72'd0, c0_active}, 80'd0);
    checkOutput("under_flag", {79'd0, err_underflow}, 80'd1);
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b1, 2'd0, '0, 1'b0, 1'b0, '0, 1'b0, 3'd0);
    checkOutput("under_sticky", {79'd0, err_underflow}, 80'd1);
    checkOutput("under_recount", {72'd0, c0_active}, 80'd3);

    // Overflow: 128 lines is legal, the 129th sets the flag and still counts.
    applyReset();
    for (int i = 0; i < 128; i++)
      applyStimulus(1'b1, 2'd0, '0, 1'b0, 1'b0, '0, 1'b0, 3'd0);
    checkOutput("ovf_at_max_count", {72'd0, c0_active}, 80'd128);
    checkOutput("ovf_at_max_flag", {79'd0, err_overflow}, 80'd0);
    applyStimulus(1'b1, 2'd0, '0, 1'b0, 1'b0, '0, 1'b0, 3'd0);
    checkOutput("ovf_count", {72'd0, c0_active}, 80'd129);
    checkOutput("ovf_flag", {79'd0, err_overflow}, 80'd1);
    applyStimulus(1'b1, 2'd2, '0, 1'b0, 1'b0, '0, 1'b0, 3'd0);
    checkOutput("c0_badlen_count", {72'd0, c0_active}, 80'd130);
    checkOutput("c0_badlen_flag", {79'd0, err_bad_len}, 80'd1);

    // Asynchronous reset in mid-cycle clears state before any clock edge.
    applyReset();
    applyStimulus(1'b0, 2'd0, '0, 1'b1, 1'b0, '0, 1'b0, 3'd0);
    fiu_c0_almost_full = 1'b1;
    for (int i = 0; i < 50; i++)
      applyStimulus(1'b0, 2'd0, '0, 1'b0, 1'b1, hdr_b, 1'b0, 3'd0);
    checkOutput("arst_pre_c1", {72'd0, c1_active}, 80'd50);
    checkOutput("arst_pre_af", {79'd0, afu_c0_almost_full}, 80'd1);
    checkOutput("arst_pre_under", {79'd0, err_underflow}, 80'd1);
    @(negedge clk);
    #1;
    reset = 1'b1;
    #1;
    checkOutput("arst_c1", {72'd0, c1_active}, 80'd0);
    checkOutput("arst_af", {78'd0, afu_c0_almost_full, afu_c1_almost_full}, 80'd0);
    checkOutput("arst_errs", {77'd0, err_overflow, err_underflow, err_bad_len}, 80'd0);
    checkOutput("arst_fiu_c1", {79'd0, fiu_c1_req_valid}, 80'd0);
    checkOutput("arst_hdr_c1", fiu_c1_req_hdr, 80'd0);
    applyReset();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
